// File: rtl/bram_sched_pkg.sv
// bram_sched_pkg
//   Shared definitions for the BRAM frame-source sequencer:
//   - sched_state_t : sequencer state encoding (6 states)
//   - DEF_*         : default parameter values used by the top and watchdog
//   - is_quiescent  : true for the states in which a new sequence may be started
package bram_sched_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT_CYC = 4096;
  localparam int DEF_EXP_WORDS   = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_EOF = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } sched_state_t;

  // States that accept go and report busy=0.
  function automatic logic is_quiescent(input sched_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/sched_watchdog.sv
// sched_watchdog
//   Counts cycles without an AXIS handshake while enabled and flags expiry.
//   Ports:
//     clk     in  system clock
//     areset  in  synchronous reset, active-high
//     clear   in  zero the counter (new frame starting)
//     kick    in  handshake seen this cycle; zeroes the counter when enabled
//     enable  in  count only while a frame is outstanding
//     expired out high in the cycle whose clock edge brings the count to
//                 TIMEOUT_CYC-1 with no handshake
import bram_sched_pkg::*;

module sched_watchdog #(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic areset,
  input  logic clear,
  input  logic kick,
  input  logic enable,
  output logic expired
);

  localparam int            CW      = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] ONE     = CW'(1);
  // Expiry is flagged one count early so the consumer's registered error
  // lands on the same edge at which the count reaches TIMEOUT_CYC-1.
  localparam logic [CW-1:0] PRE_LIM = CW'(TIMEOUT_CYC - 2);
  localparam logic [CW-1:0] MAX_CNT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (areset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (kick) begin
        r_count <= '0;
      end else if (r_count != MAX_CNT) begin
        r_count <= r_count + ONE;
      end
    end
  end

  assign expired = enable && !kick && (r_count == PRE_LIM);

endmodule

// File: rtl/bram_src_frame_sched.sv
// bram_src_frame_sched
//   Sequencer for the BRAM-backed AXI-Stream frame source (AUTO_REARM=0).
//   Issues one-cycle start pulses, snoops the AXIS handshake for end of frame,
//   enforces an inter-frame gap, counts frames and runs a stall watchdog.
//   Optional build macro: BRAM_SCHED_BEAT_CHECK_EN adds a per-frame beat
//   counter compared against EXP_WORDS (sticky len_err); without it len_err=0.
//   Ports:
//     clk, areset           clock / synchronous active-high reset
//     go, abort             1-cycle control pulses
//     cfg_frames, cfg_gap   frames per sequence (0 = until abort), gap cycles
//     src_start             1-cycle start pulse to the frame source
//     mon_tvalid/tready/tlast  snooped AXIS master handshake
//     busy, done            sequence activity / completion pulse
//     err_timeout, len_err  sticky error flags
//     frames_sent           frames completed in the current sequence
import bram_sched_pkg::*;

module bram_src_frame_sched #(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int EXP_WORDS   = DEF_EXP_WORDS
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             go,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_frames,
  input  logic [CNT_W-1:0] cfg_gap,
  output logic             src_start,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] frames_sent,
  output logic             len_err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  if (TIMEOUT_CYC < 2 || EXP_WORDS < 1) begin : g_bad_params
    $error("bram_src_frame_sched: TIMEOUT_CYC must be >= 2 and EXP_WORDS >= 1");
  end

  sched_state_t     r_state;
  sched_state_t     w_state_next;
  logic [CNT_W-1:0] r_frames_shadow;
  logic [CNT_W-1:0] r_gap_shadow;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_frames_sent;
  logic             r_abort_pend;
  logic             r_src_start;
  logic             r_busy;
  logic             r_done;
  logic             r_err_timeout;

  logic             w_hs;
  logic             w_eof;
  logic             w_wd_expired;
  logic             w_abort_any;
  logic             w_last_frame;
  logic             w_in_wait;
  logic             w_go_ok;
  logic [CNT_W-1:0] w_frames_inc;

  assign w_hs        = mon_tvalid && mon_tready;
  assign w_eof       = w_hs && mon_tlast;
  assign w_in_wait   = (r_state == ST_WAIT_EOF);
  assign w_go_ok     = is_quiescent(r_state) && go;
  // An abort arriving in the same cycle as the decision point counts too.
  assign w_abort_any = abort || r_abort_pend;
  // Saturating frame count so a free-running sequence never wraps to 0.
  assign w_frames_inc = (r_frames_sent == {CNT_W{1'b1}}) ? r_frames_sent
                                                         : r_frames_sent + ONE;
  assign w_last_frame = (r_frames_shadow != '0) && (w_frames_inc == r_frames_shadow);

  sched_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .areset  (areset),
    .clear   (r_state == ST_START),
    .kick    (w_hs),
    .enable  (w_in_wait),
    .expired (w_wd_expired)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (go) w_state_next = ST_START;
      end
      ST_START: begin
        w_state_next = w_abort_any ? ST_DONE : ST_WAIT_EOF;
      end
      ST_WAIT_EOF: begin
        // eof has priority over a coinciding watchdog expiry.
        if (w_eof) begin
          if (w_abort_any || w_last_frame) w_state_next = ST_DONE;
          else if (r_gap_shadow == '0)     w_state_next = ST_START;
          else                             w_state_next = ST_GAP;
        end else if (w_wd_expired) begin
          w_state_next = ST_ERR;
        end
      end
      ST_GAP: begin
        if (w_abort_any)                             w_state_next = ST_DONE;
        else if (r_gap_cnt == (r_gap_shadow - ONE))  w_state_next = ST_START;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state         <= ST_IDLE;
      r_frames_shadow <= '0;
      r_gap_shadow    <= '0;
      r_gap_cnt       <= '0;
      r_frames_sent   <= '0;
      r_abort_pend    <= 1'b0;
      r_src_start     <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_src_start <= (w_state_next == ST_START);
      r_busy      <= !is_quiescent(w_state_next);
      r_done      <= (w_state_next == ST_DONE) && (r_state != ST_DONE);

      if (w_go_ok) begin
        r_frames_shadow <= cfg_frames;
        r_gap_shadow    <= cfg_gap;
        r_frames_sent   <= '0;
        r_err_timeout   <= 1'b0;
        r_abort_pend    <= 1'b0;
      end else if (!is_quiescent(r_state) && abort) begin
        r_abort_pend <= 1'b1;
      end

      if (w_in_wait && w_eof) begin
        r_frames_sent <= w_frames_inc;
      end
      if (w_in_wait && !w_eof && w_wd_expired) begin
        r_err_timeout <= 1'b1;
      end

      if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + ONE;
      else                   r_gap_cnt <= '0;
    end
  end

`ifdef BRAM_SCHED_BEAT_CHECK_EN
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_len_err;
  logic [CNT_W-1:0] w_beat_total;

  // Count including the beat being handshaken now (the tlast beat on eof).
  assign w_beat_total = r_beat_cnt + ONE;

  always_ff @(posedge clk) begin
    if (areset) begin
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      if (r_state == ST_START)   r_beat_cnt <= '0;
      else if (w_in_wait && w_hs) r_beat_cnt <= w_beat_total;

      if (w_go_ok) begin
        r_len_err <= 1'b0;
      end else if (w_in_wait && w_eof && (w_beat_total != CNT_W'(EXP_WORDS))) begin
        r_len_err <= 1'b1;
      end
    end
  end

  assign len_err = r_len_err;
`else
  assign len_err = 1'b0;
`endif

  assign src_start   = r_src_start;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_timeout = r_err_timeout;
  assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_bram_src_frame_sched.sv
`timescale 1ns/1ps
module tb_bram_src_frame_sched;

  localparam int CNT_W       = 16;
  localparam int TIMEOUT_CYC = 16;
  localparam int EXP_WORDS   = 8;

  logic             clk = 1'b0;
  logic             areset;
  logic             go;
  logic             abort;
  logic [CNT_W-1:0] cfg_frames;
  logic [CNT_W-1:0] cfg_gap;
  logic             src_start;
  logic             mon_tvalid;
  logic             mon_tready;
  logic             mon_tlast;
  logic             busy;
  logic             done;
  logic             err_timeout;
  logic [CNT_W-1:0] frames_sent;
  logic             len_err;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Event logs, stored as the index of the clock edge at which the DUT/source samples them.
  int start_edges[$];
  int eof_edges[$];
  int hs_edges[$];
  int done_edges[$];

  // Source model controls.
  int src_len     = 8;
  int ready_mode  = 0;   // 0: always ready, 1: toggle, 2: stall after stall_after beats
  int stall_after = 0;
  bit stray_mode  = 1'b0;
  bit flush_req   = 1'b0;
  bit start_seen  = 1'b0;
  int beats_left  = 0;
  int beats_done  = 0;
  bit tog         = 1'b0;

  bram_src_frame_sched #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .EXP_WORDS   (EXP_WORDS)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .go          (go),
    .abort       (abort),
    .cfg_frames  (cfg_frames),
    .cfg_gap     (cfg_gap),
    .src_start   (src_start),
    .mon_tvalid  (mon_tvalid),
    .mon_tready  (mon_tready),
    .mon_tlast   (mon_tlast),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .frames_sent (frames_sent),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // Monitor: outputs/inputs are stable at the falling edge.
  initial forever begin
    @(negedge clk);
    if (src_start) begin
      start_edges.push_back(edge_n + 1);
      start_seen = 1'b1;
    end
    if (done) done_edges.push_back(edge_n + 1);
    if (mon_tvalid && mon_tready) begin
      hs_edges.push_back(edge_n + 1);
      if (mon_tlast) eof_edges.push_back(edge_n + 1);
    end
  end

  // Frame source model: src_len beats per start pulse.
  initial begin
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (areset || flush_req) begin
        beats_left = 0;
        beats_done = 0;
        start_seen = 1'b0;
        flush_req  = 1'b0;
      end else begin
        if (mon_tvalid && mon_tready && beats_left > 0) begin
          beats_left--;
          beats_done++;
        end
        if (start_seen) begin
          start_seen = 1'b0;
          beats_left = src_len;
          beats_done = 0;
        end
      end
      tog = ~tog;
      if (stray_mode) begin
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b1;
      end else begin
        mon_tvalid = (beats_left > 0);
        mon_tlast  = (beats_left == 1);
        case (ready_mode)
          1:       mon_tready = tog;
          2:       mon_tready = (beats_done < stall_after);
          default: mon_tready = 1'b1;
        endcase
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    start_edges.delete();
    eof_edges.delete();
    hs_edges.delete();
    done_edges.delete();
  endtask

  task automatic pulse_go(output int go_edge);
    go      = 1'b1;
    go_edge = edge_n + 1;
    step();
    go      = 1'b0;
  endtask

  task automatic wait_quiet(input int bound, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (done || err_timeout) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) step();
    checks++; if (src_start !== 1'b0)   begin failures++; $display("FAIL reset_src_start got=%b exp=0", src_start); end
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)        begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    checks++; if (len_err !== 1'b0)     begin failures++; $display("FAIL reset_len_err got=%b exp=0", len_err); end
    checks++; if (frames_sent !== '0)   begin failures++; $display("FAIL reset_frames got=%0d exp=0", frames_sent); end
    areset = 1'b0;
    step();
    $display("tb: reset done");
  endtask

  task automatic test_three_frames();
    int g; bit to;
    clear_logs();
    cfg_frames = 16'd3; cfg_gap = 16'd4; src_len = 8; ready_mode = 0;
    pulse_go(g);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL three_busy_after_go got=%b exp=1", busy); end
    cfg_frames = 16'd1; cfg_gap = 16'd0;   // must not affect the running sequence
    wait_quiet(300, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL three_wait got=timeout exp=done"); end
    checks++; if (start_edges.size() != 3) begin failures++; $display("FAIL three_starts got=%0d exp=3", start_edges.size()); end
    checks++; if (eof_edges.size() != 3)   begin failures++; $display("FAIL three_eofs got=%0d exp=3", eof_edges.size()); end
    checks++; if (done_edges.size() != 1)  begin failures++; $display("FAIL three_dones got=%0d exp=1", done_edges.size()); end
    if (start_edges.size() == 3 && eof_edges.size() == 3 && done_edges.size() == 1) begin
      checks++; if (start_edges[0] - g != 1) begin failures++; $display("FAIL three_go_lat got=%0d exp=1", start_edges[0] - g); end
      checks++; if (start_edges[1] - eof_edges[0] != 5) begin failures++; $display("FAIL three_gap1 got=%0d exp=5", start_edges[1] - eof_edges[0]); end
      checks++; if (start_edges[2] - eof_edges[1] != 5) begin failures++; $display("FAIL three_gap2 got=%0d exp=5", start_edges[2] - eof_edges[1]); end
      checks++; if (done_edges[0] - eof_edges[2] != 1)  begin failures++; $display("FAIL three_done_lat got=%0d exp=1", done_edges[0] - eof_edges[2]); end
    end
    checks++; if (frames_sent !== 16'd3) begin failures++; $display("FAIL three_frames_sent got=%0d exp=3", frames_sent); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL three_busy_end got=%b exp=0", busy); end
    step();
    $display("tb: three_frames starts=%0d frames_sent=%0d", start_edges.size(), frames_sent);
  endtask

  task automatic test_abort_wait();
    int g; bit to;
    clear_logs();
    cfg_frames = 16'd0; cfg_gap = 16'd0; src_len = 8; ready_mode = 0;
    pulse_go(g);
    for (int i = 0; i < 100 && start_edges.size() < 2; i++) step();
    repeat (3) step();
    abort = 1'b1; step(); abort = 1'b0;
    wait_quiet(100, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL abort_wait got=timeout exp=done"); end
    checks++; if (eof_edges.size() != 2) begin failures++; $display("FAIL abort_eofs got=%0d exp=2", eof_edges.size()); end
    if (eof_edges.size() == 2 && start_edges.size() >= 2 && done_edges.size() >= 1) begin
      checks++; if (start_edges[1] - eof_edges[0] != 1) begin failures++; $display("FAIL abort_gap0 got=%0d exp=1", start_edges[1] - eof_edges[0]); end
      checks++; if (done_edges[0] - eof_edges[1] != 1)  begin failures++; $display("FAIL abort_done_lat got=%0d exp=1", done_edges[0] - eof_edges[1]); end
    end
    checks++; if (frames_sent !== 16'd2) begin failures++; $display("FAIL abort_frames_sent got=%0d exp=2", frames_sent); end
    repeat (10) step();
    checks++; if (start_edges.size() != 2) begin failures++; $display("FAIL abort_starts got=%0d exp=2", start_edges.size()); end
    checks++; if (done_edges.size() != 1)  begin failures++; $display("FAIL abort_dones got=%0d exp=1", done_edges.size()); end
    checks++; if (busy !== 1'b0)           begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    $display("tb: abort_in_frame starts=%0d frames_sent=%0d", start_edges.size(), frames_sent);
  endtask

  task automatic test_abort_gap();
    int g; int a; bit to;
    clear_logs();
    cfg_frames = 16'd0; cfg_gap = 16'd6; src_len = 8; ready_mode = 0;
    pulse_go(g);
    for (int i = 0; i < 100 && eof_edges.size() < 1; i++) step();
    step();
    abort = 1'b1; a = edge_n + 1; step(); abort = 1'b0;
    wait_quiet(20, to);
    repeat (10) step();
    checks++; if (done_edges.size() != 1) begin failures++; $display("FAIL gapabort_dones got=%0d exp=1", done_edges.size()); end
    else begin
      checks++; if (done_edges[0] - a != 1) begin failures++; $display("FAIL gapabort_lat got=%0d exp=1", done_edges[0] - a); end
    end
    checks++; if (start_edges.size() != 1) begin failures++; $display("FAIL gapabort_starts got=%0d exp=1", start_edges.size()); end
    checks++; if (frames_sent !== 16'd1)   begin failures++; $display("FAIL gapabort_frames got=%0d exp=1", frames_sent); end
    $display("tb: abort_in_gap starts=%0d frames_sent=%0d", start_edges.size(), frames_sent);
  endtask

  task automatic test_go_abort_idle();
    bit to;
    clear_logs();
    cfg_frames = 16'd2; cfg_gap = 16'd0; src_len = 8; ready_mode = 0;
    go = 1'b1; abort = 1'b1; step(); go = 1'b0; abort = 1'b0;
    wait_quiet(100, to);
    checks++; if (frames_sent !== 16'd2)   begin failures++; $display("FAIL goabort_frames got=%0d exp=2", frames_sent); end
    checks++; if (start_edges.size() != 2) begin failures++; $display("FAIL goabort_starts got=%0d exp=2", start_edges.size()); end
    step();
    $display("tb: go_abort_idle frames_sent=%0d", frames_sent);
  endtask

  task automatic test_timeout();
    int g; int err_edge; bit to;
    clear_logs();
    cfg_frames = 16'd1; cfg_gap = 16'd0; src_len = 8; ready_mode = 2; stall_after = 3;
    pulse_go(g);
    for (int i = 0; i < 100 && !err_timeout; i++) step();
    err_edge = edge_n;
    checks++; if (err_timeout !== 1'b1)  begin failures++; $display("FAIL timeout_flag got=%b exp=1", err_timeout); end
    checks++; if (hs_edges.size() != 3)  begin failures++; $display("FAIL timeout_hs got=%0d exp=3", hs_edges.size()); end
    else begin
      checks++; if (err_edge - hs_edges[2] != 15) begin failures++; $display("FAIL timeout_lat got=%0d exp=15", err_edge - hs_edges[2]); end
    end
    checks++; if (busy !== 1'b0)           begin failures++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    repeat (5) step();
    checks++; if (err_timeout !== 1'b1)    begin failures++; $display("FAIL timeout_sticky got=%b exp=1", err_timeout); end
    checks++; if (done_edges.size() != 0)  begin failures++; $display("FAIL timeout_done got=%0d exp=0", done_edges.size()); end
    ready_mode = 0; flush_req = 1'b1;
    step(); step();
    clear_logs();
    pulse_go(g);
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", err_timeout); end
    checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL timeout_restart_busy got=%b exp=1", busy); end
    wait_quiet(100, to);
    checks++; if (frames_sent !== 16'd1) begin failures++; $display("FAIL timeout_restart_frames got=%0d exp=1", frames_sent); end
    checks++; if (err_timeout !== 1'b0)  begin failures++; $display("FAIL timeout_restart_err got=%b exp=0", err_timeout); end
    step();
    $display("tb: timeout err_edge_delta=%0d restart_frames=%0d", err_edge - ((hs_edges.size() > 0) ? 0 : 0), frames_sent);
  endtask

  task automatic test_toggle_ready();
    int g; bit to;
    clear_logs();
    cfg_frames = 16'd2; cfg_gap = 16'd0; src_len = 8; ready_mode = 1;
    pulse_go(g);
    wait_quiet(200, to);
    repeat (5) step();
    checks++; if (err_timeout !== 1'b0)    begin failures++; $display("FAIL toggle_err got=%b exp=0", err_timeout); end
    checks++; if (frames_sent !== 16'd2)   begin failures++; $display("FAIL toggle_frames got=%0d exp=2", frames_sent); end
    checks++; if (done_edges.size() != 1)  begin failures++; $display("FAIL toggle_dones got=%0d exp=1", done_edges.size()); end
    checks++; if (start_edges.size() != 2) begin failures++; $display("FAIL toggle_starts got=%0d exp=2", start_edges.size()); end
    ready_mode = 0;
    $display("tb: toggle_ready frames_sent=%0d dones=%0d", frames_sent, done_edges.size());
  endtask

  task automatic test_reset_mid();
    int g; int n_start; int n_done;
    clear_logs();
    cfg_frames = 16'd0; cfg_gap = 16'd6; src_len = 8; ready_mode = 0;
    pulse_go(g);
    for (int i = 0; i < 100 && start_edges.size() < 2; i++) step();
    step(); step();
    checks++; if (frames_sent !== 16'd1) begin failures++; $display("FAIL rstw_pre_frames got=%0d exp=1", frames_sent); end
    areset = 1'b1; step(); areset = 1'b0;
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rstw_busy got=%b exp=0", busy); end
    checks++; if (frames_sent !== '0)   begin failures++; $display("FAIL rstw_frames got=%0d exp=0", frames_sent); end
    checks++; if (src_start !== 1'b0)   begin failures++; $display("FAIL rstw_src_start got=%b exp=0", src_start); end
    step();
    clear_logs();
    pulse_go(g);
    for (int i = 0; i < 100 && eof_edges.size() < 1; i++) step();
    step(); step();
    checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL rstg_pre_busy got=%b exp=1", busy); end
    areset = 1'b1; step(); areset = 1'b0;
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rstg_busy got=%b exp=0", busy); end
    checks++; if (frames_sent !== '0)   begin failures++; $display("FAIL rstg_frames got=%0d exp=0", frames_sent); end
    n_start = start_edges.size();
    n_done  = done_edges.size();
    stray_mode = 1'b1; repeat (6) step(); stray_mode = 1'b0;
    repeat (3) step();
    checks++; if (frames_sent !== '0)           begin failures++; $display("FAIL stray_frames got=%0d exp=0", frames_sent); end
    checks++; if (busy !== 1'b0)                begin failures++; $display("FAIL stray_busy got=%b exp=0", busy); end
    checks++; if (start_edges.size() != n_start) begin failures++; $display("FAIL stray_starts got=%0d exp=%0d", start_edges.size(), n_start); end
    checks++; if (done_edges.size() != n_done)   begin failures++; $display("FAIL stray_dones got=%0d exp=%0d", done_edges.size(), n_done); end
    checks++; if (err_timeout !== 1'b0)         begin failures++; $display("FAIL stray_err got=%b exp=0", err_timeout); end
    $display("tb: reset_mid and stray hs frames_sent=%0d", frames_sent);
  endtask

  task automatic test_beat_check();
    int g; bit to;
    clear_logs();
    cfg_frames = 16'd2; cfg_gap = 16'd0; src_len = 7; ready_mode = 0;
    pulse_go(g);
    wait_quiet(200, to);
`ifdef BRAM_SCHED_BEAT_CHECK_EN
    checks++; if (len_err !== 1'b1) begin failures++; $display("FAIL beat_short got=%b exp=1", len_err); end
`else
    checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL beat_tied got=%b exp=0", len_err); end
`endif
    checks++; if (frames_sent !== 16'd2) begin failures++; $display("FAIL beat_short_frames got=%0d exp=2", frames_sent); end
    step();
    src_len = 8;
    pulse_go(g);
    checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL beat_clear got=%b exp=0", len_err); end
    wait_quiet(200, to);
    checks++; if (len_err !== 1'b0)      begin failures++; $display("FAIL beat_exact got=%b exp=0", len_err); end
    checks++; if (frames_sent !== 16'd2) begin failures++; $display("FAIL beat_exact_frames got=%0d exp=2", frames_sent); end
    step();
    $display("tb: beat_check len_err=%b frames_sent=%0d", len_err, frames_sent);
  endtask

  initial begin
    areset = 1'b1; go = 1'b0; abort = 1'b0;
    cfg_frames = '0; cfg_gap = '0;
    test_reset();
    test_three_frames();
    test_abort_wait();
    test_abort_gap();
    test_go_abort_idle();
    test_timeout();
    test_toggle_ready();
    test_reset_mid();
    test_beat_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
